// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// No logic beyond a PC alignment helper.
// No flow control in this file.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        DROP
    } fetchState_t;

    // Decode treats a non-valid slot as this instruction (addi x0,x0,0).
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    function automatic logic [31:0] alignPc(input logic [31:0] pc);
        return pc & ~32'h3;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush clears valid, load captures a new instruction.
// Latency: one clock from load to outputs.
// Backpressure: hold keeps every field; without hold or load the slot is consumed and valid drops.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        hold,
    input  logic        flush,
    input  logic [31:0] instrIn,
    input  logic [31:0] pcIn,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid   <= 1'b0;
            instr   <= '0;
            pc      <= '0;
            pcPlus4 <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid   <= 1'b1;
            instr   <= instrIn;
            pc      <= pcIn;
            pcPlus4 <= pcIn + PC_STEP;
        end else if (!hold) begin
            // Decode took the instruction last cycle and nothing new arrived.
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the fetch PC, one outstanding imem request, skid buffer and IF/ID register.
// Latency: response at edge N is on the ID outputs after edge N; next request in the following cycle.
// Backpressure: stall_d parks a response in the skid buffer; redirects squash stale responses.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall_d,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        valid_d,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d
);

    fetchState_t state, stateNext;
    logic [31:0] pcF, pcFNext;
    logic [31:0] reqPc;
    logic [31:0] skidInstr;
    logic [31:0] idInstrIn;
    logic        reqPcLoad;
    logic        skidLoad;
    logic        idLoad;

    // Gated by rst so nothing is requested while the memory side is also in reset.
    assign mem_req  = rst && (state == REQ);
    assign mem_addr = pcF;

    always_comb begin
        stateNext = state;
        pcFNext   = pcF;
        reqPcLoad = 1'b0;
        skidLoad  = 1'b0;
        idLoad    = 1'b0;
        idInstrIn = mem_rdata;

        case (state)
            REQ: begin
                if (mem_gnt) begin
                    reqPcLoad = 1'b1;
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if (stall_d) begin
                        skidLoad  = 1'b1;
                        stateNext = HOLD;
                    end else begin
                        idLoad    = 1'b1;
                        pcFNext   = reqPc + PC_STEP;
                        stateNext = REQ;
                    end
                end
            end
            HOLD: begin
                if (!stall_d) begin
                    idLoad    = 1'b1;
                    idInstrIn = skidInstr;
                    pcFNext   = reqPc + PC_STEP;
                    stateNext = REQ;
                end
            end
            DROP: begin
                if (mem_rvalid) begin
                    stateNext = REQ;
                end
            end
            default: stateNext = REQ;
        endcase

        // A redirect overrides everything; any in-flight response becomes stale.
        if (redirect_valid) begin
            pcFNext   = alignPc(redirect_pc);
            reqPcLoad = 1'b0;
            skidLoad  = 1'b0;
            idLoad    = 1'b0;
            case (state)
                REQ:     stateNext = mem_gnt ? DROP : REQ;
                WAIT:    stateNext = mem_rvalid ? REQ : DROP;
                HOLD:    stateNext = REQ;
                DROP:    stateNext = mem_rvalid ? REQ : DROP;
                default: stateNext = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= REQ;
            pcF       <= RESET_PC;
            reqPc     <= '0;
            skidInstr <= '0;
        end else begin
            state <= stateNext;
            pcF   <= pcFNext;
            if (reqPcLoad) begin
                reqPc <= pcF;
            end
            if (redirect_valid) begin
                skidInstr <= '0;
            end else if (skidLoad) begin
                skidInstr <= mem_rdata;
            end
        end
    end

    if_id_reg uIfId (
        .clk     (clk),
        .rst     (rst),
        .load    (idLoad),
        .hold    (stall_d),
        .flush   (redirect_valid),
        .instrIn (idInstrIn),
        .pcIn    (reqPc),
        .valid   (valid_d),
        .instr   (instr_d),
        .pc      (pc_d),
        .pcPlus4 (pc_plus4_d)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed table, hand-written corner sequences,
// and randomized traffic against a transaction-level fetch model.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_d;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;

    fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_d        (stall_d),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .valid_d        (valid_d),
        .instr_d        (instr_d),
        .pc_d           (pc_d),
        .pc_plus4_d     (pc_plus4_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Memory: one request in flight, response lat cycles after the grant.
    logic        memBusy;
    int          memCnt;
    logic [31:0] memAddr;
    logic [31:0] memData;
    logic        randData;

    // Fetch model: outstanding request, parked response, decode slot, next fetch address.
    logic        mOut, mStale, mPend, mValid;
    logic [31:0] mPendPc, mPendInstr, mPc, mInstr, mExpPc;

    // DUT observation for the directed sequences.
    logic [31:0] dutPcs[$];
    logic        prevV;
    logic [31:0] prevPc;
    logic [7:0]  vHist;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        memBusy = 1'b0; memCnt = 0;
        mOut = 1'b0; mStale = 1'b0; mPend = 1'b0; mValid = 1'b0;
        mExpPc = 32'h0; mPc = 32'h0; mInstr = 32'h0;
        prevV = 1'b0; prevPc = 32'h0; vHist = '0;
        dutPcs.delete();
    endtask

    task automatic doReset();
        redirect_valid = 1'b0; redirect_pc = '0; stall_d = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("reset mem_req", {31'b0, mem_req}, 32'h0);
        chk("reset valid_d", {31'b0, valid_d}, 32'h0);
        chk("reset instr_d", instr_d, 32'h0);
        chk("reset pc_d", pc_d, 32'h0);
        chk("reset pc_plus4_d", pc_plus4_d, 32'h0);
        modelReset();
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    // Drive one cycle of inputs, check the request side, clock, update model, check ID side.
    task automatic step(input logic redir, input logic [31:0] tgt, input logic stl,
                        input logic gntWant, input int lat);
        logic        xfer, rv;
        logic [31:0] rAddr, rData, reqAddr;
        redirect_valid = redir;
        redirect_pc    = tgt;
        stall_d        = stl;
        mem_gnt        = gntWant && mem_req && !memBusy;
        rv             = memBusy && (memCnt == 1);
        mem_rvalid     = rv;
        mem_rdata      = rv ? memData : 32'hDEAD_BEEF;
        chk("mem_req", {31'b0, mem_req}, {31'b0, !mOut && !mPend});
        if (!mOut && !mPend) chk("mem_addr", mem_addr, mExpPc);
        xfer    = mem_req && mem_gnt;
        reqAddr = mem_addr;
        rAddr   = memAddr;
        rData   = memData;
        @(posedge clk);
        if (rv) memBusy = 1'b0;
        else if (memBusy) memCnt--;
        if (xfer) begin
            memBusy = 1'b1;
            memCnt  = lat;
            memAddr = reqAddr;
            memData = randData ? $urandom : reqAddr;
        end
        if (redir) begin
            mValid = 1'b0;
            mPend  = 1'b0;
            mExpPc = tgt & ~32'h3;
            if (rv) mOut = 1'b0;
            if (xfer) begin mOut = 1'b1; mStale = 1'b1; end
            else if (mOut) mStale = 1'b1;
        end else begin
            if (rv) begin
                mOut = 1'b0;
                if (!mStale && stl) begin
                    mPend = 1'b1; mPendPc = rAddr; mPendInstr = rData;
                end else if (!mStale) begin
                    mValid = 1'b1; mPc = rAddr; mInstr = rData; mExpPc = rAddr + 32'd4;
                end else if (!stl) begin
                    mValid = 1'b0;
                end
            end else if (mPend && !stl) begin
                mPend = 1'b0;
                mValid = 1'b1; mPc = mPendPc; mInstr = mPendInstr; mExpPc = mPendPc + 32'd4;
            end else if (!stl) begin
                mValid = 1'b0;
            end
            if (xfer) begin mOut = 1'b1; mStale = 1'b0; end
        end
        #1;
        chk("valid_d", {31'b0, valid_d}, {31'b0, mValid});
        if (mValid) begin
            chk("pc_d", pc_d, mPc);
            chk("instr_d", instr_d, mInstr);
            chk("pc_plus4_d", pc_plus4_d, mPc + 32'd4);
        end
        if (valid_d && (!prevV || pc_d != prevPc)) dutPcs.push_back(pc_d);
        prevV  = valid_d;
        prevPc = pc_d;
        vHist  = {vHist[6:0], valid_d};
    endtask

    typedef struct {
        logic        redir;
        logic [31:0] tgt;
        int          gDly;
        int          lat;
        int          stl;
        int          expEdges;
        logic [31:0] expPc;
        logic [31:0] expInstr;
        logic [31:0] expPlus4;
        logic [31:0] expNext;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int   edges;
        logic found;
        int   nValid;
        rst = 1'b0;
        randData = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; stall_d = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        modelReset();

        vecs[0] = '{1'b0, 32'h0,         0, 1, 0, 2, 32'h0,         32'h0,         32'h4,         32'h4};
        vecs[1] = '{1'b0, 32'h0,         3, 1, 0, 5, 32'h0,         32'h0,         32'h4,         32'h4};
        vecs[2] = '{1'b1, 32'h103,       0, 2, 0, 4, 32'h100,       32'h100,       32'h104,       32'h104};
        vecs[3] = '{1'b1, 32'hFFFF_FFFF, 1, 1, 2, 6, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,         32'h0};
        vecs[4] = '{1'b1, 32'h8000_0002, 2, 3, 1, 8, 32'h8000_0000, 32'h8000_0000, 32'h8000_0004, 32'h8000_0004};

        // Single fetch from reset: edges from release to delivery and delivered fields.
        for (int v = 0; v < 5; v++) begin
            doReset();
            edges = 0;
            found = 1'b0;
            if (vecs[v].redir) begin step(1'b1, vecs[v].tgt, 1'b0, 1'b0, 1); edges++; end
            for (int i = 0; i < vecs[v].gDly; i++) begin step(1'b0, 32'h0, 1'b0, 1'b0, 1); edges++; end
            step(1'b0, 32'h0, 1'b0, 1'b1, vecs[v].lat); edges++;
            for (int i = 1; i <= 40 && !found; i++) begin
                step(1'b0, 32'h0, (i >= vecs[v].lat) && (i < vecs[v].lat + vecs[v].stl), 1'b0, 1);
                edges++;
                found = valid_d;
            end
            chk($sformatf("vec%0d edges", v), edges, vecs[v].expEdges);
            chk($sformatf("vec%0d pc_d", v), pc_d, vecs[v].expPc);
            chk($sformatf("vec%0d instr_d", v), instr_d, vecs[v].expInstr);
            chk($sformatf("vec%0d pc_plus4_d", v), pc_plus4_d, vecs[v].expPlus4);
            chk($sformatf("vec%0d next mem_req", v), {31'b0, mem_req}, 32'h1);
            chk($sformatf("vec%0d next mem_addr", v), mem_addr, vecs[v].expNext);
        end

        // Zero-wait stream: valid_d pulses every other cycle with pc 0, 4, 8.
        doReset();
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1);
        chk("stream valid pattern", {26'b0, vHist[5:0]}, 32'h15);
        chk("stream count", dutPcs.size(), 3);
        if (dutPcs.size() == 3) begin
            chk("stream pc0", dutPcs[0], 32'h0);
            chk("stream pc1", dutPcs[1], 32'h4);
            chk("stream pc2", dutPcs[2], 32'h8);
        end

        // Grant withheld three cycles on 0x10.
        step(1'b0, 32'h0, 1'b0, 1'b1, 1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1);
        for (int i = 0; i < 3; i++) begin
            chk("delay mem_req", {31'b0, mem_req}, 32'h1);
            chk("delay mem_addr", mem_addr, 32'h10);
            step(1'b0, 32'h0, 1'b0, 1'b0, 1);
        end
        nValid = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 1'b0, (i == 0), 1);
            if (valid_d) nValid++;
        end
        chk("delay single delivery", nValid, 1);
        chk("delay last pc", dutPcs[dutPcs.size()-1], 32'h10);

        // Decode stall of four cycles across the response to 0x8.
        doReset();
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 1'b1, (i == 0), 1);
            chk("stall holds valid", {31'b0, valid_d}, 32'h1);
            chk("stall holds pc", pc_d, 32'h4);
        end
        step(1'b0, 32'h0, 1'b0, 1'b0, 1);
        chk("stall release pc", pc_d, 32'h8);
        chk("stall release instr", instr_d, 32'h8);
        chk("stall next addr", mem_addr, 32'hC);

        // Redirect while waiting on 0x20: stale response dropped, target fetched next.
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1);
        chk("pre-redirect addr", mem_addr, 32'h20);
        step(1'b0, 32'h0, 1'b0, 1'b1, 3);
        step(1'b1, 32'h103, 1'b0, 1'b0, 1);
        chk("redirect clears valid", {31'b0, valid_d}, 32'h0);
        dutPcs.delete();
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1, 1);
            found = valid_d;
        end
        chk("redirect delivered pc", pc_d, 32'h100);
        chk("redirect dropped stale", dutPcs.size(), 1);

        // Redirect coincident with rvalid and stall.
        step(1'b0, 32'h0, 1'b0, 1'b1, 1);
        step(1'b1, 32'h200, 1'b1, 1'b0, 1);
        chk("coincident valid_d", {31'b0, valid_d}, 32'h0);
        chk("coincident mem_req", {31'b0, mem_req}, 32'h1);
        chk("coincident mem_addr", mem_addr, 32'h200);

        // Wraparound at the top of the address space.
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1);
        chk("wrap pc_d", pc_d, 32'hFFFF_FFFC);
        chk("wrap pc_plus4_d", pc_plus4_d, 32'h0);
        chk("wrap next addr", mem_addr, 32'h0);

        // Random traffic against the model.
        randData = 1'b1;
        doReset();
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) < 6, $urandom_range(1, 4));
        end

        // Asynchronous reset in the middle of traffic.
        doReset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
